// File: rtl/sysid_pkg.sv
// Shared register map, CONTROL bit positions and byte-lane merge helper
// for the system-identification slave.
package sysid_pkg;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_UP_LO   = 3'd2;
  localparam logic [2:0] ADDR_UP_HI   = 3'd3;
  localparam logic [2:0] ADDR_SEC     = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sysid_tick_gen.sv
// Prescaler dividing the clock down to a 32-bit seconds count.
// Clear zeroes both counters and beats freeze; freeze holds both.
module sysid_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        freeze,
  output logic [31:0] seconds
);

  localparam int PRESC_W = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] prescaler;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      seconds   <= '0;
    end else if (clear) begin
      prescaler <= '0;
      seconds   <= '0;
    end else if (!freeze) begin
      if (prescaler == PRESC_LAST) begin
        prescaler <= '0;
        seconds   <= seconds + 32'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_uptime_slave.sv
// Avalon-MM system-ID slave: ID, build time, atomic 64-bit uptime, seconds, scratch, control.
// Read latency is fixed at one cycle; no waitrequest, every access completes.
module sysid_uptime_slave
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID       = 32'h0000_0001,
  parameter logic [31:0] BUILD_TIMESTAMP = 32'h0000_0000,
  parameter int unsigned CLK_FREQ_HZ     = 50000000,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [63:0] uptime;
  logic [31:0] snap_hi;
  logic [31:0] scratch;
  logic        freeze;
  logic [31:0] seconds;
  logic [31:0] rd_mux;
  logic        ctrl_wr;
  logic        clear;

  assign ctrl_wr = write && (address == ADDR_CTRL);
  assign clear   = ctrl_wr && writedata[CTRL_CLEAR_BIT];

  sysid_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .freeze  (freeze),
    .seconds (seconds)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:      rd_mux = SYSTEM_ID;
      ADDR_TS:      rd_mux = BUILD_TIMESTAMP;
      ADDR_UP_LO:   rd_mux = uptime[31:0];
      ADDR_UP_HI:   rd_mux = snap_hi;
      ADDR_SEC:     rd_mux = seconds;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_CTRL:    rd_mux = {30'd0, freeze, 1'b0};
      default:      rd_mux = '0;
    endcase
  end

  // Read path samples pre-edge state, so a simultaneous write is seen by the next read only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      snap_hi       <= '0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (read && (address == ADDR_UP_LO)) snap_hi <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
      freeze  <= 1'b0;
    end else begin
      if (write && (address == ADDR_SCRATCH))
        scratch <= byte_merge(scratch, writedata, byteenable);
      if (ctrl_wr) freeze <= writedata[CTRL_FREEZE_BIT];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     uptime <= '0;
    else if (clear)   uptime <= '0;
    else if (!freeze) uptime <= uptime + 64'd1;
  end

endmodule
